// File: rtl/wb_port_sequencer_pkg.sv
// Shared definitions for the write-back port sequencer: rWrite codes and default sizes.
package wb_port_sequencer_pkg;

  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned ADDR_W_DEF       = 4;
  localparam int unsigned R15_ADDR_DEF     = 15;
  localparam int unsigned AUX_MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    RW_NONE    = 2'b00,
    RW_OP1     = 2'b01,
    RW_OP1_OP2 = 2'b10,
    RW_OP1_R15 = 2'b11
  } rw_code_e;

  // Number of register writes carried by one retiring instruction.
  function automatic logic [1:0] write_count(input rw_code_e code);
    case (code)
      RW_NONE: write_count = 2'd0;
      RW_OP1:  write_count = 2'd1;
      default: write_count = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/wb_pend_queue.sv
// Two-entry FIFO of pending {addr,data} writes; pop happens before the pushes of the same edge.
module wb_pend_queue #(
  parameter int unsigned ENTRY_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push0,
  input  logic [ENTRY_W-1:0] data0,
  input  logic               push1,
  input  logic [ENTRY_W-1:0] data1,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] slot0, slot1, slot0_nxt, slot1_nxt;
  logic [1:0]         cnt_pop, cnt_mid, cnt_nxt;

  // Next queue contents: shift on pop, then append push0 and push1 in order.
  always_comb begin
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    cnt_pop   = count;
    if (pop && (count != 2'd0)) begin
      slot0_nxt = slot1;
      cnt_pop   = 2'(count - 2'd1);
    end
    cnt_mid = cnt_pop;
    if (push0 && (cnt_pop != 2'd2)) begin
      if (cnt_pop == 2'd0) slot0_nxt = data0;
      else                 slot1_nxt = data0;
      cnt_mid = 2'(cnt_pop + 2'd1);
    end
    cnt_nxt = cnt_mid;
    if (push1 && (cnt_mid != 2'd2)) begin
      if (cnt_mid == 2'd0) slot0_nxt = data1;
      else                 slot1_nxt = data1;
      cnt_nxt = 2'(cnt_mid + 2'd1);
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      slot0 <= slot0_nxt;
      slot1 <= slot1_nxt;
      count <= cnt_nxt;
    end
  end

  assign head = slot0;

endmodule

// File: rtl/wb_port_sequencer.sv
// Issues up to two register writes per retiring instruction onto a single register-file
// write port, one per cycle, and shares that port with an auxiliary requester.
module wb_port_sequencer
  import wb_port_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned R15_ADDR     = R15_ADDR_DEF,
  parameter int unsigned AUX_MAX_WAIT = AUX_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rWrite,
  input  logic [ADDR_W-1:0] op1,
  input  logic [ADDR_W-1:0] op2,
  input  logic [DATA_W-1:0] op1data,
  input  logic [DATA_W-1:0] op2data,
  input  logic [DATA_W-1:0] r15data,
  output logic              stall,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_data,
  output logic              aux_gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned WAIT_W  = $clog2(AUX_MAX_WAIT + 1);

  rw_code_e           code;
  logic [1:0]         n_wr;
  logic               accept, has_wr, two_wr, force_aux;
  logic [ENTRY_W-1:0] first_w, second_w, aux_w, head, issue_w, q_data0;
  logic [1:0]         pend_cnt;
  logic               push0, push1, pop, issue;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;

  assign code      = rw_code_e'(rWrite);
  assign n_wr      = write_count(code);
  assign has_wr    = (n_wr != 2'd0);
  assign two_wr    = (n_wr == 2'd2);
  assign in_ready  = (pend_cnt == 2'd0);
  assign stall     = ~in_ready;
  assign accept    = in_valid & in_ready;
  assign force_aux = aux_req & (wait_cnt == WAIT_W'(AUX_MAX_WAIT));
  assign first_w   = {op1, op1data};
  assign second_w  = (code == RW_OP1_OP2) ? {op2, op2data} : {ADDR_W'(R15_ADDR), r15data};
  assign aux_w     = {aux_addr, aux_data};
  assign busy      = (pend_cnt != 2'd0) | wr_en;

  wb_pend_queue #(.ENTRY_W(ENTRY_W)) u_pend_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push0 (push0),
    .data0 (q_data0),
    .push1 (push1),
    .data1 (second_w),
    .pop   (pop),
    .head  (head),
    .count (pend_cnt)
  );

  // Port arbitration: forced aux, then queued writes, then bypass, then aux.
  always_comb begin
    issue   = 1'b0;
    issue_w = head;
    aux_gnt = 1'b0;
    push0   = 1'b0;
    push1   = 1'b0;
    pop     = 1'b0;
    q_data0 = first_w;
    if (force_aux) begin
      issue   = 1'b1;
      issue_w = aux_w;
      aux_gnt = 1'b1;
      if (accept && has_wr) begin
        push0 = 1'b1;
        push1 = two_wr;
      end
    end else if (pend_cnt != 2'd0) begin
      issue   = 1'b1;
      issue_w = head;
      pop     = 1'b1;
    end else if (accept && has_wr) begin
      issue   = 1'b1;
      issue_w = first_w;
      if (two_wr) begin
        push0   = 1'b1;
        q_data0 = second_w;
      end
    end else if (aux_req) begin
      issue   = 1'b1;
      issue_w = aux_w;
      aux_gnt = 1'b1;
    end
  end

  // Aux starvation counter: counts denied request cycles, saturating.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!aux_req || aux_gnt)                      wait_nxt = '0;
    else if (wait_cnt != WAIT_W'(AUX_MAX_WAIT))   wait_nxt = WAIT_W'(wait_cnt + 1'b1);
  end

  // Registered write port and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wait_cnt <= '0;
    end else begin
      wr_en    <= issue;
      wait_cnt <= wait_nxt;
      if (issue) begin
        wr_addr <= issue_w[ENTRY_W-1 -: ADDR_W];
        wr_data <= issue_w[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Scoreboard bench for wb_port_sequencer: pipeline writes queued in decode order, aux writes
// expected the cycle after their grant, port occupancy checked every cycle.
module tb_wb_port_sequencer;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned R15      = 15;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned EW       = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, stall, aux_req, aux_gnt, wr_en, busy;
  logic [1:0]        rWrite;
  logic [ADDR_W-1:0] op1, op2, aux_addr, wr_addr;
  logic [DATA_W-1:0] op1data, op2data, r15data, aux_data, wr_data;

  wb_port_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .R15_ADDR(R15), .AUX_MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .rWrite(rWrite),
    .op1(op1), .op2(op2), .op1data(op1data), .op2data(op2data), .r15data(r15data),
    .stall(stall), .aux_req(aux_req), .aux_addr(aux_addr), .aux_data(aux_data),
    .aux_gnt(aux_gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  logic [EW-1:0] pipe_q[$];
  logic          last_acc, last_rdy, aux_done;
  int            deny = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    logic          rdy, g, nxt_aux, exp_en;
    logic [EW-1:0] aux_val, w;
    #4;
    rdy = in_ready;
    g   = aux_gnt;
    chk("stall", stall, !rdy);
    if (g) chk("gnt_without_req", aux_req, 1'b1);
    last_rdy = rdy;
    last_acc = in_valid && rdy;
    if (last_acc) begin
      case (rWrite)
        2'b01: pipe_q.push_back({op1, op1data});
        2'b10: begin pipe_q.push_back({op1, op1data}); pipe_q.push_back({op2, op2data}); end
        2'b11: begin pipe_q.push_back({op1, op1data}); pipe_q.push_back({4'(R15), r15data}); end
        default: ;
      endcase
    end
    if (aux_req && !g) deny++;
    if (aux_req) chk("aux_wait_bound", deny <= MAX_WAIT, 1'b1);
    if (g || !aux_req) deny = 0;
    nxt_aux = g;
    aux_val = {aux_addr, aux_data};
    @(posedge clk);
    #1;
    exp_en = nxt_aux || (pipe_q.size() > 0);
    chk("wr_en", wr_en, exp_en);
    if (wr_en && exp_en) begin
      if (nxt_aux) w = aux_val;
      else         w = pipe_q.pop_front();
      chk("wr_addr", wr_addr, w[EW-1 -: ADDR_W]);
      chk("wr_data", wr_data, w[DATA_W-1:0]);
    end
    chk("busy", busy, exp_en || (pipe_q.size() > 0));
    if (g) begin
      aux_req  = 1'b0;
      aux_done = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] c, input logic [3:0] a1, input logic [15:0] d1,
                      input logic [3:0] a2, input logic [15:0] d2, input logic [15:0] dr,
                      output int n);
    rWrite = c; op1 = a1; op1data = d1; op2 = a2; op2data = d2; r15data = dr;
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk("send_timeout", last_acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_wr_addr"}, wr_addr, '0);
    chk({tag, "_wr_data"}, wr_data, '0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_aux_gnt"}, aux_gnt, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; rWrite = 2'b00; op1 = '0; op2 = '0;
    op1data = '0; op2data = '0; r15data = '0; aux_req = 1'b0; aux_addr = '0; aux_data = '0;
    aux_done = 1'b0; last_acc = 1'b0; last_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single write: appears the cycle after accept, no stall.
    send(2'b01, 4'd3, 16'h00CC, 4'd0, 16'h0, 16'h0, n);
    chk("t1_accept_cycles", n, 1);
    chk("t1_in_ready", in_ready, 1'b1);

    // Two writes: exactly one stall cycle, following entry accepted after it.
    send(2'b10, 4'd1, 16'h00FF, 4'd4, 16'h0031, 16'h0, n);
    rWrite = 2'b01; op1 = 4'd6; op1data = 16'h0066; in_valid = 1'b1;
    tick();
    chk("t2_stall_cycle", last_rdy, 1'b0);
    tick();
    chk("t2_next_accepted", last_acc, 1'b1);
    in_valid = 1'b0;

    // R15 second write, then empty entries.
    send(2'b11, 4'd2, 16'h1234, 4'd0, 16'h0, 16'h0090, n);
    send(2'b00, 4'd8, 16'hDEAD, 4'd9, 16'hBEEF, 16'h0, n);
    send(2'b00, 4'd8, 16'hDEAD, 4'd9, 16'hBEEF, 16'h0, n);
    repeat (3) tick();

    // Aux forced through under continuous two-write traffic.
    aux_req = 1'b1; aux_addr = 4'd7; aux_data = 16'hBEEF; aux_done = 1'b0;
    for (int k = 0; k < 8 && !aux_done; k++)
      send(2'b10, 4'(k), 16'(16'h0100 + k), 4'(k + 8), 16'(16'h0200 + k), 16'h0, n);
    chk("t4_aux_granted", aux_done, 1'b1);
    aux_req = 1'b0;
    repeat (4) tick();

    // Same destination twice: later write wins.
    send(2'b10, 4'd5, 16'h0001, 4'd5, 16'h0002, 16'h0, n);
    repeat (3) tick();
    chk("t6_final_addr", wr_addr, 4'd5);
    chk("t6_final_data", wr_data, 16'h0002);

    // Reset while a second write is queued: discarded, nothing issued after release.
    send(2'b10, 4'd9, 16'h00A1, 4'd10, 16'h00A2, 16'h0, n);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    pipe_q.delete();
    deny = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    // Random mix of entries, idle cycles and aux requests.
    for (int i = 0; i < 80; i++) begin
      if (!aux_req && ($urandom_range(0, 3) == 0)) begin
        aux_req  = 1'b1;
        aux_addr = 4'($urandom);
        aux_data = 16'($urandom);
      end
      if ($urandom_range(0, 3) != 0)
        send(2'($urandom), 4'($urandom), 16'($urandom), 4'($urandom), 16'($urandom),
             16'($urandom), n);
      else
        tick();
    end

    for (int i = 0; i < 20 && (pipe_q.size() > 0 || aux_req); i++) tick();
    chk("drain_pipe", pipe_q.size(), 0);
    chk("drain_aux", aux_req, 1'b0);
    tick();
    chk("idle_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
